// File: rtl/nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl
//
// Purpose:
//   Frequency-sweep sequencer for an NCO. A sweep configuration (start word,
//   stop word, step magnitude, dwell length, repeat and triangle flags) is
//   captured into shadow registers through a valid/ready handshake. A 'go'
//   pulse then steps the registered tuning word from start toward stop, holding
//   each word for cfg_dwell+1 cycles, clamping the last step onto the stop word.
//   At the end of a sweep the block either restarts (repeat) or pulses 'done'
//   and parks on the final word. 'abort' freezes the word and stops the sweep.
//
// Optional feature:
//   NCO_SWEEP_TRIANGLE_EN - when defined, cfg_tri=1 turns the sweep into a
//   triangle: after the stop word's dwell the sweep walks back to start
//   (sweep_dir=1) and ends when the start word's dwell expires. When the macro
//   is undefined cfg_tri is accepted but ignored and sweep_dir is tied to 0.
//
// Ports:
//   clk, rst          - clock (posedge), synchronous active-high reset
//   cfg_valid/ready   - configuration handshake; ready is high in IDLE/LOADED
//   cfg_start_inc     - start tuning word            (PHASE_ACC_BITS-1 bits)
//   cfg_stop_inc      - stop tuning word             (PHASE_ACC_BITS-1 bits)
//   cfg_step          - unsigned step magnitude      (PHASE_ACC_BITS-1 bits)
//   cfg_dwell         - cycles per word minus one    (DWELL_BITS bits)
//   cfg_repeat        - restart the sweep after its end
//   cfg_tri           - triangle sweep request
//   go, abort         - single-cycle sweep start / sweep abort
//   phase_inc         - registered tuning word to the NCO
//   nco_rst           - one-cycle pulse clearing the NCO phase accumulator
//   busy              - sweep running
//   done              - one-cycle end-of-sweep pulse
//   sweep_dir         - 0 = moving toward stop, 1 = moving back toward start
// -----------------------------------------------------------------------------
module nco_sweep_ctrl #(
  parameter int PHASE_ACC_BITS = 24,
  parameter int DWELL_BITS     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [PHASE_ACC_BITS-2:0] cfg_start_inc,
  input  logic [PHASE_ACC_BITS-2:0] cfg_stop_inc,
  input  logic [PHASE_ACC_BITS-2:0] cfg_step,
  input  logic [DWELL_BITS-1:0]     cfg_dwell,
  input  logic                      cfg_repeat,
  input  logic                      cfg_tri,
  input  logic                      go,
  input  logic                      abort,
  output logic [PHASE_ACC_BITS-2:0] phase_inc,
  output logic                      nco_rst,
  output logic                      busy,
  output logic                      done,
  output logic                      sweep_dir
);

  localparam int IW = PHASE_ACC_BITS - 1;

`ifdef NCO_SWEEP_TRIANGLE_EN
  localparam bit TRI_EN = 1'b1;
`else
  localparam bit TRI_EN = 1'b0;
`endif

  localparam logic [DWELL_BITS-1:0] DWELL_ONE = {{(DWELL_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Next word one step toward 'tgt'. The arithmetic is one bit wider than a
  // tuning word so that a step past the top of the range (or below zero) is
  // seen as an overshoot and clamped onto the target instead of wrapping.
  // ---------------------------------------------------------------------------
  function automatic logic [IW-1:0] step_toward(
    input logic [IW-1:0] cur,
    input logic [IW-1:0] tgt,
    input logic [IW-1:0] step,
    input logic          asc
  );
    logic [IW:0]   cur_x;
    logic [IW:0]   tgt_x;
    logic [IW:0]   sum_x;
    logic [IW:0]   diff_x;
    logic [IW-1:0] res;
    cur_x  = {1'b0, cur};
    tgt_x  = {1'b0, tgt};
    sum_x  = cur_x + {1'b0, step};
    diff_x = cur_x - {1'b0, step};
    if (asc) begin
      if (sum_x >= tgt_x) begin
        res = tgt;
      end else begin
        res = sum_x[IW-1:0];
      end
    end else begin
      // diff_x[IW] set means the subtraction borrowed (went below zero)
      if (diff_x[IW] || (diff_x <= tgt_x)) begin
        res = tgt;
      end else begin
        res = diff_x[IW-1:0];
      end
    end
    return res;
  endfunction

  // State and output registers
  state_e                state_q,     state_d;
  logic [IW-1:0]         phase_inc_q, phase_inc_d;
  logic                  nco_rst_q,   nco_rst_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  sweep_dir_q, sweep_dir_d;
  logic [DWELL_BITS-1:0] dwell_cnt_q, dwell_cnt_d;

  // Shadow configuration set
  logic [IW-1:0]         start_q,  start_d;
  logic [IW-1:0]         stop_q,   stop_d;
  logic [IW-1:0]         step_q,   step_d;
  logic [DWELL_BITS-1:0] dwell_q,  dwell_d;
  logic                  repeat_q, repeat_d;
  logic                  tri_q,    tri_d;

  // Decoded helpers
  logic          cfg_ready_s;
  logic          cfg_hs_s;
  logic [IW-1:0] start_eff_s;
  logic          up_s;
  logic          tri_act_s;
  logic [IW-1:0] leg_tgt_s;
  logic          leg_asc_s;
  logic          single_pt_s;
  logic          at_tgt_s;
  logic          end_sweep_s;
  logic          turn_s;
  logic          dwell_exp_s;

  assign cfg_ready_s = (state_q != ST_RUN);
  assign cfg_hs_s    = cfg_valid & cfg_ready_s;

  // A go coinciding with a handshake starts from the configuration being
  // written in that same cycle, so the sweep never mixes old and new sets.
  assign start_eff_s = cfg_hs_s ? cfg_start_inc : start_q;

  // Overall orientation of the first leg: start<=stop ascends.
  assign up_s      = (start_q <= stop_q);
  assign tri_act_s = TRI_EN & tri_q;

  // The return leg of a triangle targets start and runs the other way.
  assign leg_tgt_s = sweep_dir_q ? start_q : stop_q;
  assign leg_asc_s = up_s ^ sweep_dir_q;

  assign single_pt_s = (step_q == '0) || (start_q == stop_q);
  assign at_tgt_s    = (phase_inc_q == leg_tgt_s);
  assign end_sweep_s = single_pt_s || (at_tgt_s && (!tri_act_s || sweep_dir_q));
  assign turn_s      = at_tgt_s && tri_act_s && !sweep_dir_q;
  assign dwell_exp_s = (dwell_cnt_q == dwell_q);

  // Next-state, shadow-register and output computation
  always_comb begin
    state_d     = state_q;
    phase_inc_d = phase_inc_q;
    nco_rst_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sweep_dir_d = sweep_dir_q;
    dwell_cnt_d = dwell_cnt_q;
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    repeat_d    = repeat_q;
    tri_d       = tri_q;

    // Shadow capture is legal in IDLE and LOADED; cfg_ready already excludes RUN.
    if (cfg_hs_s) begin
      start_d  = cfg_start_inc;
      stop_d   = cfg_stop_inc;
      step_d   = cfg_step;
      dwell_d  = cfg_dwell;
      repeat_d = cfg_repeat;
      tri_d    = cfg_tri;
    end else begin
      start_d  = start_q;
    end

    case (state_q)
      ST_IDLE: begin
        // go and abort have no meaning before a configuration exists
        if (cfg_hs_s) begin
          state_d = ST_LOADED;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOADED: begin
        if (go) begin
          state_d     = ST_RUN;
          phase_inc_d = start_eff_s;
          nco_rst_d   = 1'b1;
          busy_d      = 1'b1;
          sweep_dir_d = 1'b0;
          dwell_cnt_d = '0;
        end else begin
          state_d = ST_LOADED;
        end
      end

      ST_RUN: begin
        if (abort) begin
          // abort outranks an end of sweep falling in the same cycle
          state_d     = ST_LOADED;
          busy_d      = 1'b0;
          sweep_dir_d = 1'b0;
          dwell_cnt_d = '0;
        end else if (dwell_exp_s) begin
          dwell_cnt_d = '0;
          if (end_sweep_s) begin
            if (repeat_q) begin
              // back-to-back restart: no idle cycle, no done
              phase_inc_d = start_q;
              nco_rst_d   = 1'b1;
              sweep_dir_d = 1'b0;
            end else begin
              state_d     = ST_LOADED;
              done_d      = 1'b1;
              busy_d      = 1'b0;
              sweep_dir_d = 1'b0;
            end
          end else if (turn_s) begin
            // triangle turnaround: the stop word got its one dwell, head back
            sweep_dir_d = 1'b1;
            phase_inc_d = step_toward(phase_inc_q, start_q, step_q, ~up_s);
          end else begin
            phase_inc_d = step_toward(phase_inc_q, leg_tgt_s, step_q, leg_asc_s);
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + DWELL_ONE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        sweep_dir_d = 1'b0;
        dwell_cnt_d = '0;
      end
    endcase
  end

  // State, output and shadow registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_inc_q <= '0;
      nco_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sweep_dir_q <= 1'b0;
      dwell_cnt_q <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      repeat_q    <= 1'b0;
      tri_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_inc_q <= phase_inc_d;
      nco_rst_q   <= nco_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sweep_dir_q <= sweep_dir_d;
      dwell_cnt_q <= dwell_cnt_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      repeat_q    <= repeat_d;
      tri_q       <= tri_d;
    end
  end

  assign cfg_ready = cfg_ready_s;
  assign phase_inc = phase_inc_q;
  assign nco_rst   = nco_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef NCO_SWEEP_TRIANGLE_EN
  assign sweep_dir = sweep_dir_q;
`else
  assign sweep_dir = 1'b0;
`endif

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
`timescale 1ns/1ps
module tb_nco_sweep_ctrl;

  localparam int PAB = 24;
  localparam int DB  = 16;
  localparam int IW  = PAB - 1;
  localparam longint MAXW = (longint'(1) << IW) - longint'(1);

`ifdef NCO_SWEEP_TRIANGLE_EN
  localparam bit TRI_EN = 1'b1;
`else
  localparam bit TRI_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [IW-1:0] cfg_start_inc;
  logic [IW-1:0] cfg_stop_inc;
  logic [IW-1:0] cfg_step;
  logic [DB-1:0] cfg_dwell;
  logic          cfg_repeat;
  logic          cfg_tri;
  logic          go;
  logic          abort;
  logic [IW-1:0] phase_inc;
  logic          nco_rst;
  logic          busy;
  logic          done;
  logic          sweep_dir;

  always #5 clk = ~clk;

  nco_sweep_ctrl #(.PHASE_ACC_BITS(PAB), .DWELL_BITS(DB)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_inc(cfg_start_inc), .cfg_stop_inc(cfg_stop_inc),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
    .cfg_repeat(cfg_repeat), .cfg_tri(cfg_tri),
    .go(go), .abort(abort),
    .phase_inc(phase_inc), .nco_rst(nco_rst),
    .busy(busy), .done(done), .sweep_dir(sweep_dir)
  );

  // Expected per-cycle output snapshot
  typedef struct {
    logic [IW-1:0] ph;
    logic          nr;
    logic          bz;
    logic          dn;
    logic          dr;
    logic          rdy;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  longint words_q[$];
  bit     dirs_q[$];
  longint last_ph = 0;

  function automatic exp_t mk(input longint ph, input bit nr, input bit bz,
                              input bit dn, input bit dr, input bit rdy);
    exp_t e;
    e.ph  = IW'(ph);
    e.nr  = nr;
    e.bz  = bz;
    e.dn  = dn;
    e.dr  = dr;
    e.rdy = rdy;
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: one expected snapshot per cycle while the scoreboard holds any
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("phase_inc", longint'(phase_inc), longint'(mon_e.ph));
      chk("nco_rst",   longint'(nco_rst),   longint'(mon_e.nr));
      chk("busy",      longint'(busy),      longint'(mon_e.bz));
      chk("done",      longint'(done),      longint'(mon_e.dn));
      chk("sweep_dir", longint'(sweep_dir), longint'(mon_e.dr));
      chk("cfg_ready", longint'(cfg_ready), longint'(mon_e.rdy));
    end
  end

  // Reference: list of visited words from the sweep rules with plain arithmetic
  function automatic void build_words(input longint s, input longint t,
                                      input longint st, input bit tri_on);
    longint cur;
    words_q.delete();
    dirs_q.delete();
    words_q.push_back(s);
    dirs_q.push_back(1'b0);
    if (st != 0 && s != t) begin
      cur = s;
      while (cur != t) begin
        if (s < t) cur = (cur + st >= t) ? t : cur + st;
        else       cur = (cur - st <= t) ? t : cur - st;
        words_q.push_back(cur);
        dirs_q.push_back(1'b0);
      end
      if (tri_on) begin
        while (cur != s) begin
          if (s < t) cur = (cur - st <= s) ? s : cur - st;
          else       cur = (cur + st >= s) ? s : cur + st;
          words_q.push_back(cur);
          dirs_q.push_back(1'b1);
        end
      end
    end
  endfunction

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // abort_in: -1 random, 0 none, n>0 abort during sweep cycle n
  // rst_at:   0 none, n>0 assert rst (with cfg_valid and go) during sweep cycle n
  task automatic do_sweep(input longint s, input longint t, input longint st,
                          input int dw, input bit rep, input bit tri_in,
                          input int abort_in, input int rst_at);
    exp_t tr[$];
    int   abort_at;
    int   stop_t;
    int   go_dup;
    int   passes;
    longint ph;
    build_words(s, t, st, tri_in & TRI_EN);
    passes = rep ? 3 : 1;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < words_q.size(); i++)
        for (int c = 0; c <= dw; c++)
          tr.push_back(mk(words_q[i], (i == 0 && c == 0), 1'b1, 1'b0, dirs_q[i], 1'b0));

    drain();
    // configuration cycle; abort here must be ignored
    cfg_valid     = 1'b1;
    cfg_start_inc = IW'(s);
    cfg_stop_inc  = IW'(t);
    cfg_step      = IW'(st);
    cfg_dwell     = DB'(dw);
    cfg_repeat    = rep;
    cfg_tri       = tri_in;
    abort         = 1'($urandom_range(0, 1));
    go            = 1'b0;
    exp_q.push_back(mk(last_ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk); #1;
    cfg_valid     = 1'b0;
    abort         = 1'b0;
    go            = 1'b1;
    cfg_start_inc = IW'($urandom);
    cfg_stop_inc  = IW'($urandom);
    cfg_step      = IW'($urandom);

    abort_at = abort_in;
    if (abort_in < 0 || (rep && abort_in == 0 && rst_at == 0))
      abort_at = $urandom_range(1, tr.size());
    if (rst_at > 0)        stop_t = rst_at;
    else if (abort_at > 0) stop_t = abort_at;
    else                   stop_t = tr.size();

    for (int i = 0; i < stop_t; i++) exp_q.push_back(tr[i]);
    ph = longint'(tr[stop_t-1].ph);
    if (rst_at > 0) begin
      exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      last_ph = 0;
    end else if (abort_at > 0) begin
      exp_q.push_back(mk(ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(mk(ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      last_ph = ph;
    end else begin
      exp_q.push_back(mk(ph, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      exp_q.push_back(mk(ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      last_ph = ph;
    end

    go_dup = (stop_t > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, stop_t - 1) : 0;
    for (int c = 1; c <= stop_t + 1; c++) begin
      @(negedge clk); #1;
      go        = (c == go_dup);
      abort     = (c == abort_at);
      cfg_valid = (c <= stop_t) ? 1'($urandom_range(0, 1)) : 1'b0;
      rst       = (c == rst_at);
      if (c == rst_at) begin
        cfg_valid = 1'b1;
        go        = 1'b1;
      end
    end
  endtask

  // go while IDLE must not start anything
  task automatic go_idle();
    drain();
    go = 1'b1;
    exp_q.push_back(mk(last_ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk); #1;
    go = 1'b0;
    exp_q.push_back(mk(last_ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    drain();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    longint s, t, st;
    rst = 1'b1; cfg_valid = 1'b0; go = 1'b0; abort = 1'b0;
    cfg_start_inc = '0; cfg_stop_inc = '0; cfg_step = '0; cfg_dwell = '0;
    cfg_repeat = 1'b0; cfg_tri = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    go_idle();

    do_sweep(100, 130, 10, 2, 1'b0, 1'b0, 0, 0);          // basic ascending sweep
    do_sweep(100, 125, 10, 0, 1'b0, 1'b0, 0, 0);          // clamp onto stop
    do_sweep(50, 20, 15, 1, 1'b1, 1'b0, 8, 0);            // descending, repeat
    do_sweep(100, 130, 10, 2, 1'b0, 1'b0, 5, 0);          // abort mid-word
    do_sweep(100, 130, 10, 2, 1'b0, 1'b0, 12, 0);         // abort vs end of sweep
    do_sweep(77, 200, 0, 1, 1'b0, 1'b0, 0, 0);            // step 0: single point
    do_sweep(40, 40, 5, 0, 1'b0, 1'b0, 0, 0);             // start==stop
    do_sweep(MAXW - 9, MAXW, 7, 0, 1'b0, 1'b0, 0, 0);     // overflow at top
    do_sweep(5, 0, 7, 1, 1'b0, 1'b0, 0, 0);               // borrow at bottom
    do_sweep(0, 20, 10, 0, 1'b0, 1'b1, 0, 0);             // triangle request
    do_sweep(60, 10, 20, 1, 1'b1, 1'b1, 0, 0);            // triangle, repeat
    do_sweep(100, 130, 10, 2, 1'b0, 1'b0, 0, 7);          // rst mid-run
    go_idle();                                            // shadow cleared, IDLE

    for (int n = 0; n < 30; n++) begin
      s  = $urandom_range(0, 200);
      t  = $urandom_range(0, 200);
      st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(5, 50);
      do_sweep(s, t, st, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? -1 : 0, 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter PHASE_ACC_BITS, default 24, NCO phase accumulator width; tuning words are PHASE_ACC_BITS-1 bits wide (IW).
REQ-002 SHALL have parameter DWELL_BITS, default 16, dwell counter width.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_valid  input  1  configuration offer.
REQ-006 SHALL have port cfg_ready  output  1  configuration accepted this cycle when high with cfg_valid.
REQ-007 SHALL have ports cfg_start_inc, cfg_stop_inc, cfg_step  input  IW each  start tuning word, stop tuning word and unsigned step magnitude.
REQ-008 SHALL have port cfg_dwell  input  DWELL_BITS  cycles-per-frequency minus one.
REQ-009 SHALL have ports cfg_repeat, cfg_tri  input  1 each  restart after end; triangle mode.
REQ-010 SHALL have ports go, abort  input  1 each  single-cycle sweep start and sweep abort.
REQ-011 SHALL have port phase_inc  output  IW  registered tuning word driving the NCO.
REQ-012 SHALL have port nco_rst  output  1  one-cycle pulse clearing the NCO phase accumulator.
REQ-013 SHALL have ports busy, done, sweep_dir  output  1 each  sweep running; one-cycle end-of-sweep pulse; 0=toward stop, 1=toward start.

Function
REQ-014 SHALL implement states IDLE, LOADED, RUN; cfg_ready SHALL be 1 in IDLE and LOADED and 0 in RUN (decoded from state).
REQ-015 SHALL, on cfg_valid&cfg_ready, latch all cfg_* into shadow registers and enter LOADED; a handshake in LOADED overwrites the shadow set.
REQ-016 SHALL ignore go in IDLE and RUN.
REQ-017 SHALL, on go in LOADED, enter RUN, load phase_inc=start on the next edge, pulse nco_rst in that same cycle, set busy=1 and sweep_dir=0.
REQ-018 SHALL hold each tuning word for exactly cfg_dwell+1 cycles; dwell=0 means a new word every cycle.
REQ-019 SHALL derive direction: start<=stop adds step, start>stop subtracts step.
REQ-020 SHALL compute each next word at IW+1 bits; a step overshooting the active target SHALL clamp phase_inc to the target.
REQ-021 SHALL treat the target word's dwell expiry as end of leg; step=0 or start==stop gives a single-point sweep of one dwell at start.
REQ-022 SHALL, at end of sweep with cfg_repeat=1, reload start and pulse nco_rst with no idle cycle, without asserting done.
REQ-023 SHALL, at end of sweep with cfg_repeat=0, pulse done for one cycle, return to LOADED, clear busy and hold phase_inc at the final word.
REQ-024 SHALL, on abort in RUN, return to LOADED next cycle with phase_inc frozen, busy=0 and no done; abort SHALL win over a simultaneous end of sweep; abort in IDLE/LOADED SHALL have no effect.

Reset
REQ-025 SHALL, while rst high, force state IDLE, phase_inc=0, nco_rst=0, busy=0, done=0, sweep_dir=0, dwell counter=0 and shadow registers=0; rst mid-sweep SHALL abandon the sweep without done.
REQ-026 SHALL give rst priority over cfg_valid, go and abort.

Configuration
REQ-027 SHALL honour cfg_tri only when macro NCO_SWEEP_TRIANGLE_EN is defined: on end of the up leg set sweep_dir=1 and step back toward start; the sweep ends when start's dwell expires; the turnaround word is held for a single dwell.
REQ-028 SHALL, without NCO_SWEEP_TRIANGLE_EN, keep port cfg_tri present but ignored and tie sweep_dir to 0.

Verification
REQ-029 SHALL cover: start=100, stop=130, step=10, dwell=2, repeat=0, go -> phase_inc 100,110,120,130 for 3 cycles each, nco_rst in the first cycle, done high one cycle after the last 130 cycle.
REQ-030 SHALL cover: start=100, stop=125, step=10, dwell=0 -> 100,110,120,125 then done; no value above 125.
REQ-031 SHALL cover: start=50, stop=20, step=15, dwell=1, repeat=1 -> 50,35,20 twice each, then 50 with an nco_rst pulse, and no done.
REQ-032 SHALL cover: abort on the second cycle of word 110 (REQ-029 setup) -> phase_inc stays 110, busy=0, no done, cfg_ready=1 next cycle.
REQ-033 SHALL cover: with NCO_SWEEP_TRIANGLE_EN, cfg_tri=1, start=0, stop=20, step=10, dwell=0 -> 0,10,20,10,0 then done, with sweep_dir=1 during 10,0.
REQ-034 SHALL cover: rst asserted mid-RUN with cfg_valid and go high -> all outputs at reset values the next cycle, cfg_ready=1 after rst deasserts.
